// File: rtl/cmp_bubble_sorter.sv
// -----------------------------------------------------------------------------
// cmp_bubble_sorter
//
// Purpose
//   Collects a frame of up to DEPTH 4-bit keys from a valid/ready stream,
//   sorts it ascending in place with a stable bubble sort that uses a single
//   shared 4-bit comparator (one compare per clock), then streams the sorted
//   frame out over valid/ready.
//
// Ports
//   clk         in   1  rising-edge clock
//   reset       in   1  asynchronous, active-high reset
//   in_valid    in   1  input word valid
//   in_ready    out  1  sorter accepts the input word this cycle (LOAD only)
//   in_data     in   4  input word
//   in_last     in   1  final word of the frame (qualified by the handshake)
//   out_valid   out  1  sorted word valid (DRAIN only)
//   out_ready   in   1  consumer accepts out_data this cycle
//   out_data    out  4  sorted word
//   out_last    out  1  final sorted word of the frame
//   busy        out  1  high while sorting or draining
//   swap_count  out  8  swaps performed on the current frame, saturating at 255
//
// Parameters
//   DEPTH       maximum words per frame, 2..16
// -----------------------------------------------------------------------------

// Shared magnitude comparator: exactly one of the three outputs is high.
module cmp_comparator4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic       greater_o,
  output logic       equal_o,
  output logic       less_o
);
  assign greater_o = (a_i > b_i);
  assign equal_o   = (a_i == b_i);
  assign less_o    = (a_i < b_i);
endmodule

module cmp_bubble_sorter #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic [7:0] swap_count
);

  // Word index width and frame-length width (length can equal DEPTH).
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SORT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_q, wr_d;          // next write slot during LOAD
  logic [CW-1:0]   n_q, n_d;            // words in the current frame
  logic [AW-1:0]   i_q, i_d;            // left index of the pair being compared
  logic [AW-1:0]   pass_q, pass_d;      // bubble pass number
  logic            swapped_q, swapped_d; // a swap happened earlier in this pass
  logic [AW-1:0]   rd_q, rd_d;          // next word to emit during DRAIN
  logic [7:0]      swap_count_q, swap_count_d;

  // Frame storage is deliberately not reset; it is always rewritten by LOAD
  // before it is read.
  logic [3:0]      mem_q [DEPTH];

  logic [AW-1:0]   i_plus1;
  logic [3:0]      cmp_a;
  logic [3:0]      cmp_b;
  logic            cmp_greater;
  logic            cmp_equal;
  logic            cmp_less;

  logic            load_hs;
  logic            frame_close;
  logic [CW-1:0]   n_close;
  logic            load_we;
  logic            swap_we;
  logic [CW-1:0]   last_i;
  logic            i_at_end;
  logic            pass_last;
  logic            pass_swapped;
  logic            out_hs;
  logic            drain_last;

  // ---------------------------------------------------------------------------
  // Comparator datapath: one pair per clock while sorting
  // ---------------------------------------------------------------------------
  assign i_plus1 = i_q + AW'(1);
  assign cmp_a   = mem_q[i_q];
  assign cmp_b   = mem_q[i_plus1];

  cmp_comparator4 u_cmp (
    .a_i       (cmp_a),
    .b_i       (cmp_b),
    .greater_o (cmp_greater),
    .equal_o   (cmp_equal),
    .less_o    (cmp_less)
  );

  // Only a strict Greater exchanges the pair; Equal and Less both keep the
  // current order, which is what makes the sort stable for duplicate keys.
  assign swap_we = (state_q == S_SORT) && cmp_greater && !(cmp_equal || cmp_less);

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  assign in_ready    = (state_q == S_LOAD);
  assign load_hs     = (state_q == S_LOAD) && in_valid;
  assign load_we     = load_hs;
  // The DEPTH-th word closes the frame regardless of in_last.
  assign frame_close = load_hs && (in_last || (wr_q == AW'(DEPTH - 1)));
  assign n_close     = CW'(wr_q) + CW'(1);

  // ---------------------------------------------------------------------------
  // Sort bookkeeping. Pass p compares pairs i = 0 .. N-2-p, so each pass is
  // one compare shorter than the one before.
  // ---------------------------------------------------------------------------
  assign last_i       = n_q - CW'(2) - CW'(pass_q);
  assign i_at_end     = (CW'(i_q) == last_i);
  assign pass_last    = (CW'(pass_q) == (n_q - CW'(2)));
  assign pass_swapped = swapped_q || swap_we;

  // ---------------------------------------------------------------------------
  // Output side
  // ---------------------------------------------------------------------------
  assign out_valid  = (state_q == S_DRAIN);
  assign out_hs     = (state_q == S_DRAIN) && out_ready;
  assign drain_last = (CW'(rd_q) == (n_q - CW'(1)));
  assign out_last   = (state_q == S_DRAIN) && drain_last;
  // Gated so the port reads 0 outside DRAIN (including right after reset).
  assign out_data   = (state_q == S_DRAIN) ? mem_q[rd_q] : 4'h0;
  assign busy       = (state_q == S_SORT) || (state_q == S_DRAIN);
  assign swap_count = swap_count_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    n_d          = n_q;
    i_d          = i_q;
    pass_d       = pass_q;
    swapped_d    = swapped_q;
    rd_d         = rd_q;
    swap_count_d = swap_count_q;

    unique case (state_q)
      S_IDLE: begin
        wr_d    = '0;
        state_d = S_LOAD;
      end

      S_LOAD: begin
        if (load_hs) begin
          // First word of a new frame: previous frame's count is retired.
          if (wr_q == '0) begin
            swap_count_d = 8'd0;
          end
          wr_d = wr_q + AW'(1);
          if (frame_close) begin
            n_d       = n_close;
            wr_d      = '0;
            i_d       = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
            rd_d      = '0;
            // A single-word frame is already sorted.
            state_d   = (n_close >= CW'(2)) ? S_SORT : S_DRAIN;
          end
        end
      end

      S_SORT: begin
        if (swap_we && (swap_count_q != 8'hFF)) begin
          swap_count_d = swap_count_q + 8'd1;
        end
        if (i_at_end) begin
          // A clean pass means the frame is ordered; pass N-2 is the last
          // one that can still move anything.
          if (!pass_swapped || pass_last) begin
            state_d = S_DRAIN;
            rd_d    = '0;
          end else begin
            pass_d    = pass_q + AW'(1);
            i_d       = '0;
            swapped_d = 1'b0;
          end
        end else begin
          i_d       = i_q + AW'(1);
          swapped_d = pass_swapped;
        end
      end

      S_DRAIN: begin
        if (out_hs) begin
          if (drain_last) begin
            state_d = S_LOAD;
            wr_d    = '0;
          end else begin
            rd_d = rd_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_q         <= '0;
      n_q          <= '0;
      i_q          <= '0;
      pass_q       <= '0;
      swapped_q    <= 1'b0;
      rd_q         <= '0;
      swap_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      n_q          <= n_d;
      i_q          <= i_d;
      pass_q       <= pass_d;
      swapped_q    <= swapped_d;
      rd_q         <= rd_d;
      swap_count_q <= swap_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Word storage. Writes are qualified by state, so an asserted reset (which
  // forces IDLE) blocks them without needing a reset on the array itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_q[wr_q] <= in_data;
    end
    if (swap_we) begin
      mem_q[i_q]     <= cmp_b;
      mem_q[i_plus1] <= cmp_a;
    end
  end

endmodule
